// File: rtl/cq_tx_serializer.sv
// cq_tx_serializer: pops bytes from a first-word-fall-through queue and sends
// each one as a UART-style frame on tx (start 0, 8 data bits LSB first, stop 1).
//
// state | meaning
// IDLE  | line high, waiting for a non-empty queue with en set
// START | start bit (tx = 0) for CLKS_PER_BIT cycles
// DATA  | data bits, LSB first, each held CLKS_PER_BIT cycles
// STOP  | stop bit (tx = 1); last cycle may pop the next byte back-to-back
module cq_tx_serializer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       q_empty,
  input  logic [7:0] q_dout,
  output logic       q_rd,
  output logic       tx,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] LAST_CYC = 8'(CLKS_PER_BIT - 1);

  state_t     state, state_nxt;
  logic [7:0] cyc, cyc_nxt;
  logic [2:0] bit_idx, bit_nxt;
  logic [7:0] shreg, sh_nxt;
  logic [7:0] cnt_nxt;
  logic       tx_nxt;
  logic       cyc_last;

  assign cyc_last = (cyc == LAST_CYC);
  assign busy     = (state != IDLE);

  // Next-state, pop strobe and next tx value; tx is registered from the
  // upcoming state so the start bit appears the cycle after the pop edge.
  always_comb begin
    q_rd      = reset & en & ~q_empty &
                ((state == IDLE) | ((state == STOP) & cyc_last));
    state_nxt = state;
    cyc_nxt   = cyc_last ? 8'd0 : cyc + 8'd1;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    cnt_nxt   = frame_cnt;
    tx_nxt    = 1'b1;

    case (state)
      IDLE: begin
        cyc_nxt = 8'd0;
        if (q_rd) begin
          state_nxt = START;
          sh_nxt    = q_dout;
        end
      end
      START: begin
        if (cyc_last) begin
          state_nxt = DATA;
          bit_nxt   = 3'd0;
        end
      end
      DATA: begin
        if (cyc_last) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
          end else begin
            sh_nxt  = {1'b0, shreg[7:1]};
            bit_nxt = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (cyc_last) begin
          cnt_nxt = frame_cnt + 8'd1;
          if (q_rd) begin
            state_nxt = START;
            sh_nxt    = q_dout;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = sh_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cyc       <= 8'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      frame_cnt <= 8'd0;
      tx        <= 1'b1;
    end else begin
      state     <= state_nxt;
      cyc       <= cyc_nxt;
      bit_idx   <= bit_nxt;
      shreg     <= sh_nxt;
      frame_cnt <= cnt_nxt;
      tx        <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_cq_tx_serializer.sv
// Directed bench for cq_tx_serializer with a behavioural FWFT queue model.
module tb_cq_tx_serializer;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       q_empty;
  logic [7:0] q_dout;
  logic       q_rd;
  logic       tx;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [0:1023];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  cq_tx_serializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .q_empty   (q_empty),
    .q_dout    (q_dout),
    .q_rd      (q_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  assign q_empty = (rd_ptr == wr_ptr);
  assign q_dout  = mem[rd_ptr[9:0]];

  // Queue read pointer follows the pop strobe.
  always @(posedge clk) begin
    if (q_rd) rd_ptr <= rd_ptr + 1;
  end

  // A pop from an empty queue is always an error.
  always @(negedge clk) begin
    if (q_rd && q_empty) begin
      failures++;
      $error("FAIL pop_when_empty observed=1 expected=0");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[9:0]] = d;
    wr_ptr++;
  endtask

  function automatic logic exp_tx(input logic [7:0] d, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    else if (b <= 8) return d[b-1];
    else return 1'b1;
  endfunction

  // Checks one full frame, starting just after its pop has been seen.
  task automatic frame(input logic [7:0] d, input logic next_pop,
                       input logic [7:0] cnt_before, input int drop_en_at);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (k == 0) chk("cnt_at_start", frame_cnt, cnt_before);
      chk("tx_bit", tx, exp_tx(d, k));
      chk("busy_in_frame", busy, 1'b1);
      chk("q_rd_in_frame", q_rd, (k == FRAME - 1) ? next_pop : 1'b0);
      if (k == drop_en_at) en = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    push(8'hA5);
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_cnt", frame_cnt, 8'd0);
    chk("reset_no_pop", q_rd, 1'b0);

    // Single byte.
    reset = 1'b1;
    #1 chk("pop_a5", q_rd, 1'b1);
    frame(8'hA5, 1'b0, 8'd0, -1);
    @(negedge clk);
    chk("cnt_after_a5", frame_cnt, 8'd1);
    chk("idle_busy_a5", busy, 1'b0);
    chk("idle_tx_a5", tx, 1'b1);
    chk("pops_a5", rd_ptr, 1);

    // Back-to-back.
    push(8'h00);
    push(8'hFF);
    #1 chk("pop_00", q_rd, 1'b1);
    frame(8'h00, 1'b1, 8'd1, -1);
    frame(8'hFF, 1'b0, 8'd2, -1);
    @(negedge clk);
    chk("cnt_after_b2b", frame_cnt, 8'd3);
    chk("idle_busy_b2b", busy, 1'b0);
    chk("pops_b2b", rd_ptr, 3);

    // Empty queue, then non-empty but disabled.
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("empty_idle", {q_rd, tx, busy}, 3'b010);
    end
    en = 1'b0;
    push(8'h5A);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("disabled_idle", {q_rd, tx, busy}, 3'b010);
    end
    @(negedge clk);
    en = 1'b1;
    #1 chk("pop_on_enable", q_rd, 1'b1);
    frame(8'h5A, 1'b0, 8'd3, -1);

    // en dropped during data bit 3.
    @(negedge clk);
    push(8'h3C);
    push(8'h81);
    #1 chk("pop_3c", q_rd, 1'b1);
    frame(8'h3C, 1'b0, 8'd4, 17);
    @(negedge clk);
    chk("cnt_after_3c", frame_cnt, 8'd5);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_after_en_drop", {q_rd, tx, busy}, 3'b010);
    end
    chk("pops_en_drop", rd_ptr, wr_ptr - 1);

    // Reset during data bit 5.
    push(8'h6E);
    en = 1'b1;
    #1 chk("pop_81", q_rd, 1'b1);
    for (int k = 0; k <= 24; k++) begin
      @(negedge clk);
      chk("tx_partial", tx, exp_tx(8'h81, k));
    end
    reset = 1'b0;
    #1 chk("no_pop_in_reset", q_rd, 1'b0);
    @(negedge clk);
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_cnt", frame_cnt, 8'd0);
    reset = 1'b1;
    #1 chk("pop_6e", q_rd, 1'b1);
    frame(8'h6E, 1'b0, 8'd0, -1);
    @(negedge clk);
    chk("cnt_after_6e", frame_cnt, 8'd1);

    // Counter wrap over 256 streamed frames.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("cnt_cleared", frame_cnt, 8'd0);
    for (int i = 0; i < 256; i++) push(8'(i * 7 + 3));
    #1 chk("pop_stream", q_rd, 1'b1);
    for (int i = 0; i < 256; i++) begin
      frame(8'(i * 7 + 3), (i < 255) ? 1'b1 : 1'b0, 8'(i), -1);
    end
    @(negedge clk);
    chk("cnt_wrapped", frame_cnt, 8'd0);
    chk("idle_after_stream", {q_rd, tx, busy}, 3'b010);
    chk("queue_drained", rd_ptr, wr_ptr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
